dm_responder: RTL

- Data-memory responder for the pipelined MIPS core. The core's MEM stage is the initiator; this block is the memory end that answers its load and store requests.
- Uses a valid/ready request channel and a one-cycle response pulse, with a programmable wait-state count.
- Every committed store is pushed into a trace FIFO, drained by the bench or a checker as "@pc: *addr <= data" records.

---
 rtl/dm_pkg.sv | 34 +++
 rtl/dm_responder_trace_fifo.sv | 69 ++++++
 rtl/dm_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_pkg : shared types and helpers for the data-memory responder      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dm_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_responder_trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo : store-trace FIFO with drop-on-full push and registered  |
// |              first-word-fall-through head                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module trace_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  trace_entry_t push_entry,
  output logic         push_drop,
  input  logic         pop,
  output logic         head_valid,
  output trace_entry_t head_entry
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_PTR_ONE = 1;

  trace_entry_t     r_store [DEPTH];
  trace_entry_t     r_head;
  logic [c_PTR_W:0] r_wr_ptr;
  logic [c_PTR_W:0] r_rd_ptr;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic [c_PTR_W:0] w_rd_next;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]) &&
                     (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]);
  assign w_pop     = pop && !w_empty;
  // A pop on the same edge frees the slot the push needs
  assign w_push_ok = push && (!w_full || w_pop);
  assign push_drop = push && !w_push_ok;
  assign w_rd_next = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_store[r_wr_ptr[c_PTR_W-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      r_rd_ptr <= w_rd_next;
      // Bypass the incoming entry when it becomes the new head
      if (w_push_ok && (r_wr_ptr[c_PTR_W-1:0] == w_rd_next[c_PTR_W-1:0]))
        r_head <= push_entry;
      else
        r_head <= r_store[w_rd_next[c_PTR_W-1:0]];
    end
  end

  assign head_valid = !w_empty;
  assign head_entry = r_head;

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_responder : data-memory responder for the MEM stage, with wait    |
// |                states and a store trace FIFO                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  localparam int         c_WORDS     = 2 ** ADDR_W;
  localparam bit         c_NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_t   r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [31:0] r_mem [c_WORDS];
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic        r_overflow;

  logic              w_in_idle;
  logic              w_cur_we;
  logic [31:0]       w_cur_addr;
  logic [3:0]        w_cur_be;
  logic [31:0]       w_cur_wdata;
  logic [31:0]       w_cur_pc;
  logic [ADDR_W-1:0] w_idx;
  logic              w_err;
  logic [31:0]       w_old;
  logic [31:0]       w_merged;
  logic              w_enter_resp;
  logic              w_commit;
  logic              w_trace_drop;
  trace_entry_t      w_push_entry;
  trace_entry_t      w_head_entry;

  // With no wait states the request is served straight off the inputs
  assign w_in_idle   = (r_state == IDLE);
  assign w_cur_we    = w_in_idle ? req_we    : r_we;
  assign w_cur_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_cur_be    = w_in_idle ? req_be    : r_be;
  assign w_cur_wdata = w_in_idle ? req_wdata : r_wdata;
  assign w_cur_pc    = w_in_idle ? req_pc    : r_pc;

  assign w_idx        = w_cur_addr[ADDR_W+1:2];
  assign w_err        = |w_cur_addr[31:ADDR_W+2];
  assign w_old        = r_mem[w_idx];
  assign w_merged     = byte_merge(w_old, w_cur_wdata, w_cur_be);
  assign w_enter_resp = (w_in_idle && req_valid && c_NO_WAIT) ||
                        ((r_state == WAIT) && (r_wait_cnt == 4'd0));
  assign w_commit     = w_enter_resp && w_cur_we && !w_err && (w_cur_be != 4'b0000);

  assign w_push_entry.pc   = w_cur_pc;
  assign w_push_entry.addr = w_cur_addr & ~32'h3;
  assign w_push_entry.data = w_merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_WORDS; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wait_cnt   <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_pc         <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_be        <= req_be;
            r_wdata     <= req_wdata;
            r_pc        <= req_pc;
            r_req_ready <= 1'b0;
            if (c_NO_WAIT) begin
              r_state <= RESP;
            end else begin
              r_state    <= WAIT;
              r_wait_cnt <= c_WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_wait_cnt == 4'd0) r_state <= RESP;
          else                    r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase

      if (w_enter_resp) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= w_err ? 32'h0 : (w_cur_we ? w_merged : w_old);
      end

      if (w_trace_drop) r_overflow <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_commit),
    .push_entry (w_push_entry),
    .push_drop  (w_trace_drop),
    .pop        (trace_ready),
    .head_valid (trace_valid),
    .head_entry (w_head_entry)
  );

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_rdata     = r_resp_rdata;
  assign resp_err       = r_resp_err;
  assign trace_pc       = w_head_entry.pc;
  assign trace_addr     = w_head_entry.addr;
  assign trace_data     = w_head_entry.data;
  assign trace_overflow = r_overflow;

endmodule
`default_nettype wire
